// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// tinyv_mem_pkg
// Types and constants that the word-addressed memory responder shares with
// its backing array.
//   mem_state_e : responder FSM states (IDLE / WAIT / RESP)
//   WORD_BYTES  : bytes per 32-bit word, which is also the byte-enable width
//   idx_width() : width of a word index for a given array depth
// ---------------------------------------------------------------------------
package tinyv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam int WORD_BYTES = 4;

    // A depth of one word still needs a one-bit index port.
    function automatic int idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between a load/store initiator and the memory
// responder.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = write, 0 = read
//   req_addr            : byte address
//   req_wdata, req_be   : write data and per-byte enables (bit i -> [8i+7:8i])
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : read data (0 for writes and errors), error flag
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. Once valid is raised, the sender holds valid and its payload stable
// until that edge. ready may change freely, and neither side makes ready
// depend combinationally on valid.
// ---------------------------------------------------------------------------
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, DEPTH_WORDS x 32 bits, with per-byte write
// enables. The array contents are not reset.
//   clk   : rising-edge clock
//   en    : access enable for this cycle
//   we    : 1 = write the enabled bytes, 0 = read the word into rdata
//   be    : byte enables for writes
//   addr  : word index
//   wdata : write data
//   rdata : registered read data. It changes only on a read access, so it
//           holds the last word read between reads.
// ---------------------------------------------------------------------------
module mem_array
    import tinyv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = idx_width(DEPTH_WORDS)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [WORD_BYTES-1:0]   be,
    input  logic [AW-1:0]           addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Word-addressed memory responder. It accepts one load/store request at a
// time, waits LATENCY cycles, commits the access once, and then holds the
// response until the initiator takes it.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   bus       : request/response bundle (slave side)
//   dbg_state : current FSM state
// Parameters: DEPTH_WORDS (power of two), LATENCY (0..15 wait cycles).
// ---------------------------------------------------------------------------
module mem_responder
    import tinyv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    output mem_state_e        dbg_state
);

    localparam int AW = idx_width(DEPTH_WORDS);

    mem_state_e             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [WORD_BYTES-1:0]  be_q, be_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rd_valid_q, rd_valid_d;

    logic                   access_err;
    logic                   mem_en;
    logic [31:0]            mem_rdata;

    // Misaligned, or word index beyond the array.
    assign access_err = (addr_q[1:0] != 2'b00) ||
                        ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_valid_d  = rd_valid_q;
        mem_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // The first RESP cycle issues the single array access. The
                // response registers become valid on the same edge that the
                // array captures the read word or performs the write.
                if (!rsp_valid_q) begin
                    mem_en      = !access_err;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = access_err;
                    rd_valid_d  = !access_err && !we_q;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_valid_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (we_q),
        .be    (be_q),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // The array holds its read register between reads, so masking it with a
    // registered flag keeps rsp_rdata stable for the whole response and at 0
    // for writes, errors and reset.
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rd_valid_q ? mem_rdata : 32'd0;
    assign dbg_state     = state_q;

endmodule
